// File: rtl/ctrl_ex_time_param.sv
// Exposure-time controller with synchronised up/down buttons, hold-to-repeat,
// saturating steps and a lock that defers one pending step while exposing.
module ctrl_ex_time_param #(
   parameter int WIDTH         = 6,
   parameter int MIN_T         = 2,
   parameter int MAX_T         = 30,
   parameter int DEFAULT_T     = 10,
   parameter int STEP          = 1,
   parameter int REPEAT_DELAY  = 16,
   parameter int REPEAT_PERIOD = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Exp_increase,
   input  logic             Exp_decrease,
   input  logic             Lock,
   output logic [WIDTH-1:0] EX_time,
   output logic             At_max,
   output logic             At_min,
   output logic             Changed
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT, BLOCKED} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic               incMeta_q, incS_q, decMeta_q, decS_q;
   logic [WIDTH-1:0]   ex_q, ex_d;
   logic               pendValid_q, pendValid_d;
   logic               pendDir_q, pendDir_d;
   logic               changed_q, changed_d;
   logic               stepReq;
   logic               activeBtn, otherBtn;

   // Saturating step computed one bit wider so it can never wrap.
   function automatic logic [WIDTH-1:0] stepVal(input logic [WIDTH-1:0] cur, input logic up);
      logic [WIDTH:0] ext, stp, mx, mn, res;
      ext = {1'b0, cur};
      stp = (WIDTH+1)'(STEP);
      mx  = (WIDTH+1)'(MAX_T);
      mn  = (WIDTH+1)'(MIN_T);
      if (up) res = ((ext + stp) > mx) ? mx : (ext + stp);
      else    res = (ext < (mn + stp)) ? mn : (ext - stp);
      return res[WIDTH-1:0];
   endfunction

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         incMeta_q   <= 1'b0;
         incS_q      <= 1'b0;
         decMeta_q   <= 1'b0;
         decS_q      <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         dir_q       <= 1'b0;
         ex_q        <= WIDTH'(DEFAULT_T);
         pendValid_q <= 1'b0;
         pendDir_q   <= 1'b0;
         changed_q   <= 1'b0;
      end else begin
         incMeta_q   <= Exp_increase;
         incS_q      <= incMeta_q;
         decMeta_q   <= Exp_decrease;
         decS_q      <= decMeta_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dir_q       <= dir_d;
         ex_q        <= ex_d;
         pendValid_q <= pendValid_d;
         pendDir_q   <= pendDir_d;
         changed_q   <= changed_d;
      end
   end

   assign activeBtn = dir_q ? incS_q : decS_q;
   assign otherBtn  = dir_q ? decS_q : incS_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      stepReq = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (incS_q && decS_q) begin
               state_d = BLOCKED;
            end else if (incS_q || decS_q) begin
               stepReq = 1'b1;
               dir_d   = incS_q;
               cnt_d   = CNT_W'(REPEAT_DELAY - 1);
               state_d = HOLD;
            end
         end
         HOLD, REPEAT: begin
            if (!activeBtn) begin
               state_d = IDLE;
            end else if (otherBtn) begin
               state_d = BLOCKED;
            end else if (cnt_q == '0) begin
               stepReq = 1'b1;
               cnt_d   = CNT_W'(REPEAT_PERIOD - 1);
               state_d = REPEAT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         BLOCKED: begin
            if (!incS_q && !decS_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A deferred step always takes precedence over a fresh one on unlock.
   always_comb begin
      ex_d        = ex_q;
      pendValid_d = pendValid_q;
      pendDir_d   = pendDir_q;
      if (!Lock && pendValid_q) begin
         ex_d        = stepVal(ex_q, pendDir_q);
         pendValid_d = 1'b0;
      end else if (Lock && stepReq) begin
         pendValid_d = 1'b1;
         pendDir_d   = dir_d;
      end else if (!Lock && stepReq) begin
         ex_d = stepVal(ex_q, dir_d);
      end
      changed_d = (ex_d != ex_q);
   end

   assign EX_time = ex_q;
   assign At_max  = (ex_q == WIDTH'(MAX_T));
   assign At_min  = (ex_q == WIDTH'(MIN_T));
   assign Changed = changed_q;

endmodule

// File: tb/tb_ctrl_ex_time_param.sv
// Directed bench for ctrl_ex_time_param with short repeat timing (delay 8, period 4).
module tb_ctrl_ex_time_param;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       incBtn;
   logic       decBtn;
   logic       lockIn;
   logic [5:0] exTime;
   logic       atMax;
   logic       atMin;
   logic       changed;

   int testsRun    = 0;
   int testsFailed = 0;
   int pulses;

   ctrl_ex_time_param #(
      .WIDTH(6), .MIN_T(2), .MAX_T(30), .DEFAULT_T(10), .STEP(1),
      .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .Exp_increase(incBtn),
      .Exp_decrease(decBtn),
      .Lock(lockIn),
      .EX_time(exTime),
      .At_max(atMax),
      .At_min(atMin),
      .Changed(changed)
   );

   always #5 Clk = ~Clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Three-cycle press followed by enough idle time for the controller to settle.
   task automatic applyStimulus(input bit up);
      if (up) incBtn = 1'b1; else decBtn = 1'b1;
      tick(3);
      incBtn = 1'b0;
      decBtn = 1'b0;
      tick(6);
   endtask

   task automatic doReset();
      Reset = 1'b1;
      tick(2);
      Reset = 1'b0;
      tick(1);
   endtask

   initial begin
      Reset  = 1'b1;
      incBtn = 1'b0;
      decBtn = 1'b0;
      lockIn = 1'b0;
      tick(2);
      checkOutput("reset_ex", 32'(exTime), 10);
      Reset = 1'b0;
      tick(1);
      checkOutput("idle_ex", 32'(exTime), 10);
      checkOutput("idle_atmin", 32'(atMin), 0);
      checkOutput("idle_atmax", 32'(atMax), 0);
      checkOutput("idle_changed", 32'(changed), 0);

      incBtn = 1'b1;
      tick(2);
      checkOutput("pulse_k1", 32'(exTime), 10);
      tick(1);
      incBtn = 1'b0;
      checkOutput("pulse_k2", 32'(exTime), 11);
      checkOutput("pulse_changed", 32'(changed), 1);
      tick(1);
      checkOutput("pulse_changed_end", 32'(changed), 0);
      tick(12);
      checkOutput("pulse_settled", 32'(exTime), 11);

      doReset();
      incBtn = 1'b1;
      tick(3);
      checkOutput("hold_k2", 32'(exTime), 11);
      tick(7);
      checkOutput("hold_k9", 32'(exTime), 11);
      tick(1);
      checkOutput("hold_k10", 32'(exTime), 12);
      tick(4);
      checkOutput("hold_k14", 32'(exTime), 13);
      tick(24);
      checkOutput("hold_k38", 32'(exTime), 19);
      tick(1);
      incBtn = 1'b0;
      tick(20);
      checkOutput("hold_released", 32'(exTime), 19);

      for (int i = 0; i < 10; i++) applyStimulus(1'b1);
      checkOutput("at29_ex", 32'(exTime), 29);
      checkOutput("at29_atmax", 32'(atMax), 0);
      incBtn = 1'b1;
      tick(3);
      checkOutput("sat_ex", 32'(exTime), 30);
      checkOutput("sat_atmax", 32'(atMax), 1);
      pulses = 0;
      repeat (40) begin
         tick(1);
         if (changed) pulses++;
      end
      checkOutput("sat_no_changed", 32'(pulses), 0);
      checkOutput("sat_hold_ex", 32'(exTime), 30);
      incBtn = 1'b0;
      tick(8);

      doReset();
      for (int i = 0; i < 7; i++) applyStimulus(1'b0);
      checkOutput("at3_ex", 32'(exTime), 3);
      decBtn = 1'b1;
      tick(3);
      checkOutput("min_ex", 32'(exTime), 2);
      checkOutput("min_atmin", 32'(atMin), 1);
      pulses = 0;
      repeat (30) begin
         tick(1);
         if (changed) pulses++;
      end
      checkOutput("min_no_changed", 32'(pulses), 0);
      checkOutput("min_hold_ex", 32'(exTime), 2);
      decBtn = 1'b0;
      tick(8);

      doReset();
      incBtn = 1'b1;
      decBtn = 1'b1;
      tick(10);
      checkOutput("both_ex", 32'(exTime), 10);
      decBtn = 1'b0;
      tick(10);
      checkOutput("both_dec_released", 32'(exTime), 10);
      incBtn = 1'b0;
      tick(5);
      checkOutput("both_released", 32'(exTime), 10);
      incBtn = 1'b1;
      tick(3);
      checkOutput("after_blocked_ex", 32'(exTime), 11);
      incBtn = 1'b0;
      tick(8);

      doReset();
      lockIn = 1'b1;
      tick(1);
      applyStimulus(1'b0);
      checkOutput("lock_dec_hold", 32'(exTime), 10);
      applyStimulus(1'b1);
      checkOutput("lock_inc_hold", 32'(exTime), 10);
      lockIn = 1'b0;
      tick(1);
      checkOutput("unlock_ex", 32'(exTime), 11);
      checkOutput("unlock_changed", 32'(changed), 1);
      tick(1);
      checkOutput("unlock_changed_end", 32'(changed), 0);
      tick(5);
      checkOutput("unlock_settled", 32'(exTime), 11);

      doReset();
      incBtn = 1'b1;
      tick(23);
      checkOutput("repeat_at15", 32'(exTime), 15);
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("async_reset_ex", 32'(exTime), 10);
      checkOutput("async_reset_changed", 32'(changed), 0);
      tick(1);
      Reset = 1'b0;
      tick(2);
      checkOutput("rehold_k1", 32'(exTime), 10);
      tick(1);
      checkOutput("rehold_k2", 32'(exTime), 11);
      incBtn = 1'b0;
      tick(8);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/ctrl_ex_time_param.md
Name: ctrl_ex_time_param

Overview:
- Parametrised exposure-time controller for the camera control path. Output EX_time feeds the exposure/readout sequencer.
- Successor to the fixed 6-bit, 2..30 exposure register. Adds these features:
  - configurable range, step and width
  - 2-flop input synchronisers on the button inputs
  - hold-to-auto-repeat
  - a Lock input that defers changes while an exposure is running
  - min/max flags and a change pulse

Parameters:
- WIDTH, 6: width of EX_time.
- MIN_T, 2: lowest allowed EX_time.
- MAX_T, 30: highest allowed EX_time.
- DEFAULT_T, 10: EX_time value after reset.
- STEP, 1: amount added or removed per step.
- REPEAT_DELAY, 16: number of Clk cycles a button must be held before the first auto-repeat step.
- REPEAT_PERIOD, 4: number of Clk cycles between auto-repeat steps after the first one.
- Legal values: MIN_T <= DEFAULT_T <= MAX_T < 2**WIDTH, STEP >= 1, REPEAT_DELAY >= 2, REPEAT_PERIOD >= 1.

Ports:
- Clk  input  1  system clock, rising-edge active.
- Reset  input  1  asynchronous reset, active-high.
- Exp_increase  input  1  increase button, asynchronous level.
- Exp_decrease  input  1  decrease button, asynchronous level.
- Lock  input  1  synchronous to Clk. 1 = exposure in progress, so EX_time must hold.
- EX_time  output  WIDTH  current exposure time.
- At_max  output  1  high when EX_time == MAX_T.
- At_min  output  1  high when EX_time == MIN_T.
- Changed  output  1  one-cycle pulse in the cycle after EX_time took a new value.

Behaviour:
- Reset (asynchronous, active-high). While Reset is high:
  - EX_time = DEFAULT_T; At_max and At_min are decoded from that value; Changed = 0.
  - FSM = IDLE; synchronisers, counters and pending state are cleared.
- Clocking: one clock (Clk); all state updates on its rising edge.
- Synchronisers: each button passes through 2 flops, giving inc_s and dec_s.
- Latency: if k is the first edge that samples a button high, inc_s/dec_s go high at edge k+1. The first step is applied to EX_time at edge k+2.
- FSM states and transitions:
  - IDLE: only one of inc_s/dec_s high -> take one step, load repeat counter with REPEAT_DELAY-1, store direction, go to HOLD. Both high -> go to BLOCKED with no step.
  - HOLD: active button released -> IDLE. Other button rises -> BLOCKED. Otherwise decrement the counter; when it reaches 0, take one step, reload with REPEAT_PERIOD-1 and go to REPEAT.
  - REPEAT: same as HOLD, but every reload uses REPEAT_PERIOD-1. Releasing the button -> IDLE.
  - BLOCKED: no steps. Stay until both inc_s and dec_s are 0, then go to IDLE. A press of both buttons together never moves EX_time.
- Step arithmetic: compute in WIDTH+1 bits, saturating, never wrapping.
  - Increase: if EX_time + STEP > MAX_T, the result is MAX_T.
  - Decrease: if EX_time < MIN_T + STEP, the result is MIN_T.
  - A step taken at a limit leaves EX_time unchanged, and Changed stays 0.
- Lock behaviour:
  - While Lock = 1, steps are not applied to EX_time. The FSM keeps running.
  - Each step generated under Lock overwrites a one-entry pending register holding the direction plus a valid bit. The last request wins; requests do not accumulate.
  - On the first edge where Lock = 0 and pending is valid, the pending step is applied with saturation and pending is cleared.
  - If the FSM also generates a step on that same edge, the pending step is applied first and the new step is discarded.
- Changed: registered. It is 1 for exactly one cycle, in the cycle after the edge where EX_time took a value different from its previous one.
- At_max / At_min: combinational decode of the EX_time register, valid in the same cycle as EX_time.
- Reset mid-hold or mid-lock:
  - All state returns to its reset value immediately; the pending step is lost.
  - A button still held when Reset falls is treated as a new press: first step 2 edges after inc_s sees it, with no glitch step.
- Buttons asserted for less than one Clk period may be missed. This is accepted behaviour.

Test Plan (bench overrides REPEAT_DELAY=8, REPEAT_PERIOD=4; other parameters at default):
- Reset released, no input -> EX_time=10, At_min=0, At_max=0, Changed=0.
- Single Exp_increase pulse, 3 cycles long -> EX_time goes from 10 to 11 at edge k+2. Changed is high for one cycle. No further steps.
- Exp_increase held 40 cycles starting at EX_time=10:
  - steps at edges k+2, k+10, then every 4 cycles;
  - EX_time=19 at edge k+38;
  - after release EX_time stays 19.
- Start at 29, hold Exp_increase long -> EX_time saturates at 30 and At_max=1. No wrap, no further Changed pulses. Mirror case: from 3 with Exp_decrease -> EX_time reaches 2 and At_min=1.
- Both buttons rise on the same cycle at EX_time=10 -> EX_time stays 10 throughout. Release Exp_decrease only -> still no step. Release both, then press Exp_increase -> EX_time=11.
- Lock=1, then Exp_decrease pulse, then Exp_increase pulse, at EX_time=10 -> EX_time holds 10 while locked. Edge after Lock falls -> EX_time=11 (last request wins) and Changed pulses.
- Reset asserted asynchronously mid-REPEAT at EX_time=15 -> EX_time=10 immediately, without waiting for a clock edge.
